// File: rtl/reverse_shifter_pipe.sv
// reverse_shifter_pipe
//   Two-stage valid/ready pipeline that applies one of eight bit-permutation
//   or shift operations to each accepted word. Stage S1 captures the operand,
//   mode and amount; stage S2 holds the computed result.
//
//   Build option: define REVERSE_SHIFTER_STATS_EN to build a saturating
//   16-bit count of completed output transfers on xfer_count. Without it,
//   xfer_count is tied to zero.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   in_valid    input word present
//   in_ready    block accepts the input word this cycle
//   in_data     operand, WIDTH bits
//   in_mode     000 pass, 001 bit reverse, 010 group reverse, 011 rotl,
//               100 rotr, 101 shl, 110 shr, 111 sra
//   in_amt      shift/rotate amount, clog2(WIDTH) bits
//   out_valid   result present
//   out_ready   downstream accepts the result
//   out_data    result, WIDTH bits
//   xfer_count  completed output transfers (0 unless stats are built)

module reverse_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [2:0]                 in_mode,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [15:0]                xfer_count
);

  localparam int AW = $clog2(WIDTH);
  localparam int NG = WIDTH / GROUP;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [2:0]       s1_mode;
  logic [AW-1:0]    s1_amt;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_load;
  logic             s1_load;

  function automatic logic [WIDTH-1:0] compute(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic [AW-1:0]    amt
  );
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] dd;
    logic [AW-1:0]      rot_amt;
    logic               big;
    r  = '0;
    dd = {d, d};
    // Amounts at or above WIDTH only exist for non-power-of-two widths and
    // are always below 2*WIDTH, so one conditional subtract is a full modulo.
    big     = (int'(amt) >= WIDTH);
    rot_amt = big ? AW'(int'(amt) - WIDTH) : amt;
    case (mode)
      3'b000: r = d;
      3'b001: begin
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      end
      3'b010: begin
        for (int k = 0; k < NG; k++) r[k*GROUP +: GROUP] = d[(NG-1-k)*GROUP +: GROUP];
      end
      3'b011: begin
        // Upper half of the doubled word shifted left is the left rotation.
        dd = dd << rot_amt;
        r  = dd[2*WIDTH-1:WIDTH];
      end
      3'b100: begin
        dd = dd >> rot_amt;
        r  = dd[WIDTH-1:0];
      end
      3'b101: r = big ? '0 : (d << amt);
      3'b110: r = big ? '0 : (d >> amt);
      default: r = big ? {WIDTH{d[WIDTH-1]}} : WIDTH'($signed(d) >>> amt);
    endcase
    return r;
  endfunction

  // S2 frees up whenever it is empty or its word leaves this cycle; S1 can
  // then refill in the same cycle, which gives full throughput and lets a
  // full pipeline advance while accepting a new word.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s1_amt   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_mode <= in_mode;
          s1_amt  <= in_amt;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= compute(s1_data, s1_mode, s1_amt);
      end
    end
  end

`ifdef REVERSE_SHIFTER_STATS_EN
  logic [15:0] xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (s2_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  assign xfer_count = xfer_cnt;
`else
  assign xfer_count = '0;
`endif

endmodule
